ula_multiciclo: RTL

//  Parametrised, handshaked ALU for the datapath. Single-cycle logic/arith ops,

---
 rtl/ula_pkg.sv | 34 +++
 rtl/ula_comb_core.sv | 58 +++++
 rtl/ula_multiciclo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM encoding, flag indices.
package ula_pkg;

   localparam logic [3:0] ULA_AND  = 4'b0000;
   localparam logic [3:0] ULA_OR   = 4'b0001;
   localparam logic [3:0] ULA_ADD  = 4'b0010;
   localparam logic [3:0] ULA_NOR  = 4'b0011;
   localparam logic [3:0] ULA_SLL  = 4'b0100;
   localparam logic [3:0] ULA_SRL  = 4'b0101;
   localparam logic [3:0] ULA_SUB  = 4'b0110;
   localparam logic [3:0] ULA_SLTU = 4'b0111;
   localparam logic [3:0] ULA_MUL  = 4'b1000;
   localparam logic [3:0] ULA_SRA  = 4'b1001;
   localparam logic [3:0] ULA_SLT  = 4'b1010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } ula_state_t;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 3;

   // Reset value of the flag vector: result is zero, so only Z is set.
   localparam logic [3:0] FLAGS_RST = 4'b1000;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ULA_SLL) || (op == ULA_SRL) || (op == ULA_SRA);
   endfunction

endpackage

// File: rtl/ula_comb_core.sv
// Combinational single-cycle ALU ops with their Z/N/C/V flags; unknown opcodes give 0.
module ula_comb_core
   import ula_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;
   logic           add_v;
   logic           sub_v;

   assign sum   = {1'b0, a} + {1'b0, b};
   assign dif   = {1'b0, a} - {1'b0, b};
   assign add_v = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (sum[WIDTH-1] ^ a[WIDTH-1]);
   assign sub_v =  (a[WIDTH-1] ^ b[WIDTH-1]) & (dif[WIDTH-1] ^ a[WIDTH-1]);

   // dif[WIDTH] is the unsigned borrow of A-B, shared by SUB, SLT and SLTU.
   always_comb begin
      result = '0;
      flags  = '0;
      case (op)
         ULA_AND: result = a & b;
         ULA_OR:  result = a | b;
         ULA_NOR: result = ~(a | b);
         ULA_ADD: begin
            result        = sum[WIDTH-1:0];
            flags[FLAG_C] = sum[WIDTH];
            flags[FLAG_V] = add_v;
         end
         ULA_SUB: begin
            result        = dif[WIDTH-1:0];
            flags[FLAG_C] = dif[WIDTH];
            flags[FLAG_V] = sub_v;
         end
         ULA_SLT: begin
            result        = {{(WIDTH-1){1'b0}}, dif[WIDTH-1] ^ sub_v};
            flags[FLAG_C] = dif[WIDTH];
            flags[FLAG_V] = sub_v;
         end
         ULA_SLTU: begin
            result        = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
            flags[FLAG_C] = dif[WIDTH];
            flags[FLAG_V] = sub_v;
         end
         default: result = '0;
      endcase
      flags[FLAG_Z] = (result == '0);
      flags[FLAG_N] = result[WIDTH-1];
   end

endmodule

// File: rtl/ula_multiciclo.sv
// Handshaked multicycle ALU: single-cycle ops via ula_comb_core, 1-bit/cycle shifts,
// shift-add multiplier. One operation in flight; result held until consumed.
module ula_multiciclo
   import ula_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ULAControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ULAResult,
   output logic             Z,
   output logic             N,
   output logic             C,
   output logic             V
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; in_ready is high only in IDLE, out_valid only in DONE, and DONE holds
   // result/flags unchanged until out_ready is seen.

   localparam int SHW = $clog2(WIDTH);
   localparam int CW  = $clog2(WIDTH + 1);

   ula_state_t          state, state_nxt;
   logic [3:0]          op_q;
   logic [WIDTH-1:0]    a_q, b_q, sh_q, mb_q, sh_nxt;
   logic [2*WIDTH-1:0]  mc_q, acc_q, acc_nxt;
   logic [CW-1:0]       cnt_q, cnt_init;
   logic [WIDTH-1:0]    result_q, core_res, fin_res;
   logic [3:0]          flags_q, core_flags, fin_flags;
   logic [SHW-1:0]      shamt_in;
   logic                accept, last, mul_q;

   ula_comb_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (core_res),
      .flags  (core_flags)
   );

   assign accept   = in_valid && in_ready;
   assign last     = (state == ST_EXEC) && (cnt_q == CW'(1));
   assign shamt_in = SrcB[SHW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)    state_nxt = ST_EXEC;
         ST_EXEC: if (last)      state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   // Iterations spent in EXEC; a zero shift still takes one cycle.
   always_comb begin
      cnt_init = CW'(1);
      if (is_shift(ULAControl) && (shamt_in != '0)) cnt_init = CW'(shamt_in);
      else if (MUL_EN && (ULAControl == ULA_MUL))   cnt_init = CW'(WIDTH);
   end

   always_comb begin
      sh_nxt = sh_q;
      if (b_q[SHW-1:0] != '0) begin
         case (op_q)
            ULA_SLL: sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
            ULA_SRL: sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
            ULA_SRA: sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            default: sh_nxt = sh_q;
         endcase
      end
      acc_nxt = acc_q + (mb_q[0] ? mc_q : '0);
   end

   always_comb begin
      fin_res   = core_res;
      fin_flags = core_flags;
      if (is_shift(op_q)) begin
         fin_res   = sh_nxt;
         fin_flags = '0;
      end else if (mul_q) begin
         fin_res           = acc_nxt[WIDTH-1:0];
         fin_flags         = '0;
         fin_flags[FLAG_C] = |acc_nxt[2*WIDTH-1:WIDTH];
         fin_flags[FLAG_V] = |acc_nxt[2*WIDTH-1:WIDTH];
      end
      if (is_shift(op_q) || mul_q) begin
         fin_flags[FLAG_Z] = (fin_res == '0);
         fin_flags[FLAG_N] = fin_res[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= ULA_AND;
         mul_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         sh_q     <= '0;
         mb_q     <= '0;
         mc_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flags_q  <= FLAGS_RST;
      end else if (accept) begin
         op_q  <= ULAControl;
         mul_q <= MUL_EN && (ULAControl == ULA_MUL);
         a_q   <= SrcA;
         b_q   <= SrcB;
         sh_q  <= SrcA;
         mb_q  <= SrcB;
         mc_q  <= {{WIDTH{1'b0}}, SrcA};
         acc_q <= '0;
         cnt_q <= cnt_init;
      end else if (state == ST_EXEC) begin
         sh_q  <= sh_nxt;
         mb_q  <= {1'b0, mb_q[WIDTH-1:1]};
         mc_q  <= {mc_q[2*WIDTH-2:0], 1'b0};
         acc_q <= acc_nxt;
         cnt_q <= cnt_q - CW'(1);
         if (last) begin
            result_q <= fin_res;
            flags_q  <= fin_flags;
         end
      end
   end

   assign ULAResult = result_q;
   assign Z         = flags_q[FLAG_Z];
   assign N         = flags_q[FLAG_N];
   assign C         = flags_q[FLAG_C];
   assign V         = flags_q[FLAG_V];

endmodule
